// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared FSM state, default sizing and the shared 1-bit adder
package adder_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF = 16;
  function automatic logic [1:0] add2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first set req bit at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    // Walk offsets from farthest to nearest so the nearest set bit wins
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      idx_o = req_i[j] ? j : idx_o;
    end
  end
  assign any_o = |req_i;
  assign gnt_o = any_o ? N'(1) << idx_o : '0;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin shared 1-bit adder with one-deep registered response
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_op1,
  input  logic [NUM_REQ-1:0]         req_op2,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_ans,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  input  logic                       rsp_ready,
  output logic [CNT_W-1:0]           done_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic op1_q, op1_d, op2_q, op2_d;
  logic [IW-1:0] id_q, id_d, ptr_q, ptr_d, gidx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt;
  logic any, accept, grant;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gidx),
    .any_o(any)
  );
  always_comb begin
    accept = (state_q == IDLE) || rsp_ready;
    // rst_n gating keeps req_ready quiet while reset is held
    grant = accept && any && rst_n;
    state_d = grant ? BUSY : (rsp_ready ? IDLE : state_q);
    op1_d = grant ? req_op1[gidx] : op1_q;
    op2_d = grant ? req_op2[gidx] : op2_q;
    id_d = grant ? gidx : id_q;
    ptr_d = grant ? ((gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1) : ptr_q;
    cnt_d = cnt_q + CNT_W'(rsp_valid && rsp_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op1_q <= 1'b0;
      op2_q <= 1'b0;
      id_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready = grant ? gnt : '0;
  assign rsp_valid = state_q == BUSY;
  assign rsp_ans = add2(op1_q, op2_q);
  assign rsp_id = id_q;
  assign done_cnt = cnt_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: vector table, corner sequences and randomized model check
module tb_adder_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req_valid = '0, req_op1 = '0, req_op2 = '0, req_ready, req_ready4;
  logic rsp_valid, rsp_valid4;
  logic [1:0] rsp_ans, rsp_ans4, rsp_id, rsp_id4;
  logic [15:0] done_cnt;
  logic [3:0] done_cnt4;
  int checks = 0, errors = 0;
  bit mbusy;
  int mans, mid, mptr, mcnt;

  adder_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ans(rsp_ans), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .done_cnt(done_cnt)
  );
  adder_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_ans(rsp_ans4), .rsp_id(rsp_id4),
    .rsp_ready(rsp_ready), .done_cnt(done_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v, o1, o2;
    logic rr;
    logic [3:0] er;
    logic ev;
    logic [1:0] ea, ei;
    int ec;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    mbusy = 0; mans = 0; mid = 0; mptr = 0; mcnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_cnt", done_cnt, 0);
    check("rst_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] o1, input logic [3:0] o2, input logic rr);
    int g;
    logic [3:0] er;
    req_valid = v; req_op1 = o1; req_op2 = o2; rsp_ready = rr;
    #1;
    g = (!mbusy || rr) ? pick(v, mptr) : -1;
    er = (g >= 0) ? 4'(1 << g) : 4'd0;
    check("m_ready", req_ready, er);
    check("m_ready4", req_ready4, er);
    @(posedge clk); #1;
    if (mbusy && rr) mcnt++;
    if (g >= 0) begin
      mbusy = 1; mans = int'(o1[g]) + int'(o2[g]); mid = g; mptr = (g + 1) % N;
    end else if (rr) mbusy = 0;
    check("m_valid", rsp_valid, mbusy);
    if (mbusy) begin
      check("m_ans", rsp_ans, mans);
      check("m_id", rsp_id, mid);
    end
    check("m_cnt", done_cnt, mcnt % 65536);
    check("m_cnt4", done_cnt4, mcnt % 16);
  endtask

  initial begin
    tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2, 0};
    tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 1};
    tbl[2] = '{4'b1001, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd1, 2'd3, 1};
    tbl[3] = '{4'b1001, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 2'd0, 2};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd0, 2};
    tbl[5] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd0, 2};
    tbl[6] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1, 3};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0, 4};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].v; req_op1 = tbl[i].o1; req_op2 = tbl[i].o2; rsp_ready = tbl[i].rr;
      #1;
      check($sformatf("t%0d_ready", i), req_ready, tbl[i].er);
      @(posedge clk); #1;
      check($sformatf("t%0d_valid", i), rsp_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("t%0d_ans", i), rsp_ans, tbl[i].ea);
        check($sformatf("t%0d_id", i), rsp_id, tbl[i].ei);
      end
      check($sformatf("t%0d_cnt", i), done_cnt, tbl[i].ec);
    end
    // fairness
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'($urandom), 4'($urandom), 1'b1);
      check("fair_id", rsp_id, i % 4);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("fair_cnt", done_cnt, 8);
    // backpressure
    do_reset();
    step(4'b0010, 4'b0000, 4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0110, 4'($urandom), 4'($urandom), 1'b0);
      check("bp_ans", rsp_ans, 1);
      check("bp_id", rsp_id, 1);
      check("bp_cnt", done_cnt, 0);
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("bp_done", done_cnt, 1);
    // reset while busy
    do_reset();
    step(4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 4'b0100, 1'b1);
    check("rm_ans", rsp_ans, 2);
    check("rm_cnt1", done_cnt, 1);
    req_valid = 4'b1111; rsp_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rm_valid", rsp_valid, 0);
    check("rm_cnt0", done_cnt, 0);
    check("rm_ready", req_ready, 0);
    do_reset();
    step(4'b1111, 4'b0000, 4'b0000, 1'b1);
    check("rm_first", rsp_id, 0);
    // counter wrap on the narrow instance
    do_reset();
    for (int i = 0; i < 17; i++) step(4'b1111, 4'($urandom), 4'($urandom), 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("wrap_cnt4", done_cnt4, 1);
    check("wrap_cnt16", done_cnt, 17);
    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
